// File: rtl/lsu_riscv_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, access size codes, lane helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package lsu_riscv_pkg;

    // Access size codes as driven by the decoder (RISC-V funct3 of LOAD/STORE)
    localparam logic [2:0] LDST_B  = 3'b000;
    localparam logic [2:0] LDST_H  = 3'b001;
    localparam logic [2:0] LDST_W  = 3'b010;
    localparam logic [2:0] LDST_BU = 3'b100;
    localparam logic [2:0] LDST_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_GNT,
        WAIT_RVAL,
        RESP
    } lsu_state_t;

    // Codes with no defined meaning behave as a signed byte access
    function automatic logic [2:0] norm_size(input logic [2:0] size);
        logic [2:0] r;
        r = LDST_B;
        case (size)
            LDST_B, LDST_H, LDST_W, LDST_BU, LDST_HU: r = size;
            default:                                  r = LDST_B;
        endcase
        return r;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] off);
        logic r;
        r = 1'b0;
        case (norm_size(size))
            LDST_H, LDST_HU: r = off[0];
            LDST_W:          r = (off != 2'b00);
            default:         r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] off);
        logic [3:0] r;
        r = 4'b0001 << off;
        case (norm_size(size))
            LDST_H, LDST_HU: r = 4'b0011 << {off[1], 1'b0};
            LDST_W:          r = 4'b1111;
            default:         r = 4'b0001 << off;
        endcase
        return r;
    endfunction

    // Replicate the store operand across every lane it could land in
    function automatic logic [31:0] store_data(input logic [2:0] size, input logic [31:0] d);
        logic [31:0] r;
        r = {4{d[7:0]}};
        case (norm_size(size))
            LDST_H, LDST_HU: r = {2{d[15:0]}};
            LDST_W:          r = d;
            default:         r = {4{d[7:0]}};
        endcase
        return r;
    endfunction

    // Pick the addressed lane out of the read word and extend it to 32 bits
    function automatic logic [31:0] load_extract(input logic [2:0] size, input logic [1:0] off,
                                                 input logic [31:0] word);
        logic [31:0] b_sh;
        logic [31:0] h_sh;
        logic [31:0] r;
        b_sh = word >> {off, 3'b000};
        h_sh = word >> {off[1], 4'b0000};
        r    = {{24{b_sh[7]}}, b_sh[7:0]};
        case (norm_size(size))
            LDST_BU: r = {24'h000000, b_sh[7:0]};
            LDST_H:  r = {{16{h_sh[15]}}, h_sh[15:0]};
            LDST_HU: r = {16'h0000, h_sh[15:0]};
            LDST_W:  r = word;
            default: r = {{24{b_sh[7]}}, b_sh[7:0]};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lsu_riscv_if.sv
// Data-memory port bundle between the load/store unit and the memory (req/gnt/rvalid protocol).
// Latency: n/a (wires only).
// Backpressure: memory stalls requests by withholding data_gnt_i; responses come on data_rvalid_i.
interface lsu_riscv_if;
    logic        data_req_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_addr_o;
    logic [31:0] data_wdata_o;
    logic        data_gnt_i;
    logic        data_rvalid_i;
    logic [31:0] data_rdata_i;

    modport master (
        output data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
        input  data_gnt_i, data_rvalid_i, data_rdata_i
    );

    modport slave (
        input  data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
        output data_gnt_i, data_rvalid_i, data_rdata_i
    );
endinterface

// File: rtl/lsu_riscv_align.sv
// Lane steering: byte enables and replicated store data, plus load lane extract/extend.
// Latency: purely combinational.
// Backpressure: none.
module lsu_riscv_align
    import lsu_riscv_pkg::*;
(
    input  logic [2:0]  st_size,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_data,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata,
    output logic        st_misalign,
    input  logic [2:0]  ld_size,
    input  logic [1:0]  ld_off,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);
    assign st_be       = byte_en(st_size, st_off);
    assign st_wdata    = store_data(st_size, st_data);
    assign st_misalign = is_misaligned(st_size, st_off);
    assign ld_data     = load_extract(ld_size, ld_off, ld_rdata);
endmodule

// File: rtl/lsu_riscv.sv
// Load/store unit: issues one LOAD/STORE on the data-memory port and returns extended load data.
// Latency: store 2 cycles, load 3 cycles minimum; extra cycles for each withheld gnt/rvalid.
// Backpressure: lsu_stall_req_o holds the pipeline until the single-cycle RESP state.
module lsu_riscv
    import lsu_riscv_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC     = 0,
    parameter bit          STORE_WAIT_RVAL = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [2:0]  lsu_size_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_data_i,
    output logic [31:0] lsu_data_o,
    output logic        lsu_stall_req_o,
    output logic        lsu_misalign_o,
    output logic        lsu_fault_o,
    lsu_riscv_if.master dmem
);
    // Counter only needs to reach TIMEOUT_CYC-1; the last wait cycle triggers the fault
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : '0;

    lsu_state_t  state_q, state_d;
    logic [31:0] addr_q, data_q, rdata_q, rdata_d;
    logic [2:0]  size_q;
    logic        we_q;
    logic        misalign_q, misalign_d;
    logic        fault_q, fault_d;
    logic [CNT_W-1:0] cnt_q;

    logic        issue_live;
    logic        req;
    logic        latch;
    logic        timeout_hit;
    logic [2:0]  sel_size;
    logic [31:0] sel_addr, sel_data;
    logic        sel_we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        misalign;
    logic [31:0] ld_ext;

    // In IDLE the request goes out from the live decoder fields; afterwards from the latched copy
    assign issue_live = (state_q == IDLE);
    assign sel_size   = issue_live ? lsu_size_i : size_q;
    assign sel_addr   = issue_live ? lsu_addr_i : addr_q;
    assign sel_data   = issue_live ? lsu_data_i : data_q;
    assign sel_we     = issue_live ? lsu_we_i   : we_q;

    assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_q == TO_LAST);

    lsu_riscv_align u_align (
        .st_size     (sel_size),
        .st_off      (sel_addr[1:0]),
        .st_data     (sel_data),
        .st_be       (be),
        .st_wdata    (wdata),
        .st_misalign (misalign),
        .ld_size     (size_q),
        .ld_off      (addr_q[1:0]),
        .ld_rdata    (dmem.data_rdata_i),
        .ld_data     (ld_ext)
    );

    // Next-state, request, stall and response-flag decode
    always_comb begin
        state_d         = state_q;
        lsu_stall_req_o = 1'b0;
        req             = 1'b0;
        latch           = 1'b0;
        misalign_d      = 1'b0;
        fault_d         = 1'b0;
        rdata_d         = rdata_q;
        case (state_q)
            IDLE: begin
                lsu_stall_req_o = lsu_req_i;
                if (lsu_req_i) begin
                    latch   = 1'b1;
                    rdata_d = '0;
                    if (misalign) begin
                        misalign_d = 1'b1;
                        state_d    = RESP;
                    end else begin
                        req = 1'b1;
                        if (dmem.data_gnt_i)
                            state_d = (!lsu_we_i || STORE_WAIT_RVAL) ? WAIT_RVAL : RESP;
                        else
                            state_d = WAIT_GNT;
                    end
                end
            end
            WAIT_GNT: begin
                lsu_stall_req_o = 1'b1;
                req             = 1'b1;
                if (dmem.data_gnt_i) begin
                    state_d = (!we_q || STORE_WAIT_RVAL) ? WAIT_RVAL : RESP;
                end else if (timeout_hit) begin
                    fault_d = 1'b1;
                    state_d = RESP;
                end
            end
            WAIT_RVAL: begin
                lsu_stall_req_o = 1'b1;
                if (dmem.data_rvalid_i) begin
                    if (!we_q)
                        rdata_d = ld_ext;
                    state_d = RESP;
                end else if (timeout_hit) begin
                    fault_d = 1'b1;
                    rdata_d = '0;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Memory port is quiet (all zero) whenever no request is being presented
    assign dmem.data_req_o   = req;
    assign dmem.data_we_o    = req & sel_we;
    assign dmem.data_be_o    = req ? be : 4'b0000;
    assign dmem.data_addr_o  = req ? {sel_addr[31:2], 2'b00} : 32'h0;
    assign dmem.data_wdata_o = req ? wdata : 32'h0;

    assign lsu_data_o     = (state_q == RESP) ? rdata_q : 32'h0;
    assign lsu_misalign_o = misalign_q;
    assign lsu_fault_o    = fault_q;

    // FSM state and response registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            rdata_q    <= '0;
            misalign_q <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rdata_q    <= rdata_d;
            misalign_q <= misalign_d;
            fault_q    <= fault_d;
        end
    end

    // Capture the access fields when a request is taken in IDLE
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q <= '0;
            data_q <= '0;
            size_q <= '0;
            we_q   <= 1'b0;
        end else if (latch) begin
            addr_q <= lsu_addr_i;
            data_q <= lsu_data_i;
            size_q <= lsu_size_i;
            we_q   <= lsu_we_i;
        end
    end

    // Wait-cycle counter: restarts on every state change, counts while waiting on memory
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (state_d != state_q) begin
            cnt_q <= '0;
        end else if (state_q == WAIT_GNT || state_q == WAIT_RVAL) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_lsu_riscv.sv
// Directed bench for the load/store unit: loads, stores, misalignment, timeout and reset abort.
// Latency: checks cycle-exact stall/request timing against hand-derived values.
// Backpressure: memory gnt/rvalid driven per cycle from the stimulus sequences.
module tb_lsu_riscv;
    import lsu_riscv_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Main DUT (wait forever, store completes on gnt)
    logic        req, we;
    logic [2:0]  size;
    logic [31:0] addr, wdat;
    logic [31:0] ldata;
    logic        stall, mis, flt;
    lsu_riscv_if mem();

    // Timeout DUT (TIMEOUT_CYC = 4)
    logic        t_req, t_we;
    logic [2:0]  t_size;
    logic [31:0] t_addr, t_wdat;
    logic [31:0] t_ldata;
    logic        t_stall, t_mis, t_flt;
    lsu_riscv_if mem_to();

    lsu_riscv u_dut (
        .clk_i(clk), .rst_i(rst),
        .lsu_req_i(req), .lsu_we_i(we), .lsu_size_i(size), .lsu_addr_i(addr), .lsu_data_i(wdat),
        .lsu_data_o(ldata), .lsu_stall_req_o(stall), .lsu_misalign_o(mis), .lsu_fault_o(flt),
        .dmem(mem)
    );

    lsu_riscv #(.TIMEOUT_CYC(4)) u_to (
        .clk_i(clk), .rst_i(rst),
        .lsu_req_i(t_req), .lsu_we_i(t_we), .lsu_size_i(t_size), .lsu_addr_i(t_addr),
        .lsu_data_i(t_wdat),
        .lsu_data_o(t_ldata), .lsu_stall_req_o(t_stall), .lsu_misalign_o(t_mis),
        .lsu_fault_o(t_flt),
        .dmem(mem_to)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic load_seq(input string tag, input logic [2:0] sz, input logic [31:0] a,
                            input logic [31:0] rd, input logic [3:0] ebe, input logic [31:0] ed);
        logic [31:0] wa;
        wa = {a[31:2], 2'b00};
        req = 1'b1; we = 1'b0; size = sz; addr = a; wdat = 32'h0;
        mem.data_gnt_i = 1'b1;
        #1;
        chk({tag, "/issue_stall"}, 32'(stall), 32'd1);
        chk({tag, "/issue_req"}, 32'(mem.data_req_o), 32'd1);
        chk({tag, "/issue_we"}, 32'(mem.data_we_o), 32'd0);
        chk({tag, "/be"}, 32'(mem.data_be_o), 32'(ebe));
        chk({tag, "/addr"}, mem.data_addr_o, wa);
        @(negedge clk);
        mem.data_gnt_i = 1'b0; mem.data_rvalid_i = 1'b1; mem.data_rdata_i = rd;
        #1;
        chk({tag, "/rval_stall"}, 32'(stall), 32'd1);
        chk({tag, "/rval_req"}, 32'(mem.data_req_o), 32'd0);
        @(negedge clk);
        mem.data_rvalid_i = 1'b0; mem.data_rdata_i = 32'h0;
        #1;
        chk({tag, "/resp_stall"}, 32'(stall), 32'd0);
        chk({tag, "/resp_data"}, ldata, ed);
        chk({tag, "/resp_flags"}, {30'd0, mis, flt}, 32'd0);
        @(negedge clk);
        req = 1'b0;
        #1;
        chk({tag, "/idle_data"}, ldata, 32'h0);
        @(negedge clk);
    endtask

    task automatic store_seq(input string tag, input logic [2:0] sz, input logic [31:0] a,
                             input logic [31:0] d, input logic [3:0] ebe, input logic [31:0] ewd);
        req = 1'b1; we = 1'b1; size = sz; addr = a; wdat = d;
        mem.data_gnt_i = 1'b1;
        #1;
        chk({tag, "/issue_stall"}, 32'(stall), 32'd1);
        chk({tag, "/issue_req"}, 32'(mem.data_req_o), 32'd1);
        chk({tag, "/issue_we"}, 32'(mem.data_we_o), 32'd1);
        chk({tag, "/be"}, 32'(mem.data_be_o), 32'(ebe));
        chk({tag, "/wdata"}, mem.data_wdata_o, ewd);
        @(negedge clk);
        mem.data_gnt_i = 1'b0;
        #1;
        chk({tag, "/resp_stall"}, 32'(stall), 32'd0);
        chk({tag, "/resp_req"}, 32'(mem.data_req_o), 32'd0);
        chk({tag, "/resp_data"}, ldata, 32'h0);
        @(negedge clk);
        req = 1'b0; we = 1'b0;
        @(negedge clk);
    endtask

    task automatic misalign_seq(input string tag, input logic w, input logic [2:0] sz,
                                input logic [31:0] a);
        req = 1'b1; we = w; size = sz; addr = a; wdat = 32'hFFFF_FFFF;
        #1;
        chk({tag, "/issue_req"}, 32'(mem.data_req_o), 32'd0);
        chk({tag, "/issue_stall"}, 32'(stall), 32'd1);
        chk({tag, "/issue_mis"}, 32'(mis), 32'd0);
        @(negedge clk);
        #1;
        chk({tag, "/resp_stall"}, 32'(stall), 32'd0);
        chk({tag, "/resp_req"}, 32'(mem.data_req_o), 32'd0);
        chk({tag, "/resp_flags"}, {30'd0, mis, flt}, 32'd2);
        chk({tag, "/resp_data"}, ldata, 32'h0);
        @(negedge clk);
        req = 1'b0; we = 1'b0;
        #1;
        chk({tag, "/after_mis"}, 32'(mis), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req = 1'b0; we = 1'b0; size = 3'b000; addr = 32'h0; wdat = 32'h0;
        t_req = 1'b0; t_we = 1'b0; t_size = 3'b000; t_addr = 32'h0; t_wdat = 32'h0;
        mem.data_gnt_i = 1'b0; mem.data_rvalid_i = 1'b0; mem.data_rdata_i = 32'h0;
        mem_to.data_gnt_i = 1'b0; mem_to.data_rvalid_i = 1'b0; mem_to.data_rdata_i = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst/state", 32'(u_dut.state_q), 32'(IDLE));
        chk("rst/outs", {28'd0, stall, mis, flt, mem.data_req_o}, 32'd0);
        chk("rst/data", ldata, 32'h0);
        chk("rst/be_addr", {mem.data_addr_o[31:4], mem.data_be_o}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Loads with gnt on the issue cycle and rvalid on the next
        load_seq("lw",    LDST_W,  32'h0000_0100, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);
        load_seq("lb",    LDST_B,  32'h0000_0103, 32'h8012_3456, 4'b1000, 32'hFFFF_FF80);
        load_seq("lbu",   LDST_BU, 32'h0000_0103, 32'h8012_3456, 4'b1000, 32'h0000_0080);
        load_seq("lh",    LDST_H,  32'h0000_0102, 32'h8001_7777, 4'b1100, 32'hFFFF_8001);
        load_seq("lhu",   LDST_HU, 32'h0000_0100, 32'h1234_F00D, 4'b0011, 32'h0000_F00D);
        load_seq("sz011", 3'b011,  32'h0000_0101, 32'h0000_AB00, 4'b0010, 32'hFFFF_FFAB);
        load_seq("sz111", 3'b111,  32'h0000_0102, 32'h0012_0000, 4'b0100, 32'h0000_0012);

        // Stores granted on the issue cycle
        store_seq("sb", LDST_B, 32'h0000_0101, 32'h0000_0055, 4'b0010, 32'h5555_5555);
        store_seq("sw", LDST_W, 32'h0000_0200, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);

        // SH with gnt withheld 3 cycles; live inputs scrambled while waiting
        req = 1'b1; we = 1'b1; size = LDST_H; addr = 32'h0000_0102; wdat = 32'h1234_ABCD;
        mem.data_gnt_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                addr = 32'hFFFF_FFF1; wdat = 32'h0;
            end
            if (i == 3) mem.data_gnt_i = 1'b1;
            #1;
            chk($sformatf("sh_wait%0d/req", i), 32'(mem.data_req_o), 32'd1);
            chk($sformatf("sh_wait%0d/stall", i), 32'(stall), 32'd1);
            chk($sformatf("sh_wait%0d/addr", i), mem.data_addr_o, 32'h0000_0100);
            chk($sformatf("sh_wait%0d/be_we", i), {27'd0, mem.data_we_o, mem.data_be_o}, 32'h1C);
            chk($sformatf("sh_wait%0d/wdata", i), mem.data_wdata_o, 32'hABCD_ABCD);
            @(negedge clk);
        end
        mem.data_gnt_i = 1'b0;
        #1;
        chk("sh/resp_stall", 32'(stall), 32'd0);
        chk("sh/resp_req", 32'(mem.data_req_o), 32'd0);
        chk("sh/resp_data", ldata, 32'h0);
        @(negedge clk);
        req = 1'b0; we = 1'b0; addr = 32'h0;
        #1;
        chk("sh/idle_stall", 32'(stall), 32'd0);
        chk("sh/idle_state", 32'(u_dut.state_q), 32'(IDLE));
        @(negedge clk);

        // Misaligned accesses: no memory traffic, one-cycle misalign pulse
        misalign_seq("lw_mis", 1'b0, LDST_W,  32'h0000_0101);
        misalign_seq("sh_mis", 1'b1, LDST_H,  32'h0000_0103);
        misalign_seq("lhu_mis", 1'b0, LDST_HU, 32'h0000_0105);

        // gnt and rvalid together on issue: that rvalid is not the response
        req = 1'b1; we = 1'b0; size = LDST_W; addr = 32'h0000_0104;
        mem.data_gnt_i = 1'b1; mem.data_rvalid_i = 1'b1; mem.data_rdata_i = 32'h1111_1111;
        @(negedge clk);
        mem.data_gnt_i = 1'b0; mem.data_rdata_i = 32'h2222_2222;
        @(negedge clk);
        mem.data_rvalid_i = 1'b0; mem.data_rdata_i = 32'h0;
        #1;
        chk("rv_same/resp_stall", 32'(stall), 32'd0);
        chk("rv_same/resp_data", ldata, 32'h2222_2222);
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);

        // Timeout in WAIT_GNT: 4 waiting cycles then fault
        t_req = 1'b1; t_we = 1'b0; t_size = LDST_W; t_addr = 32'h0000_0010;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("to_gnt%0d/req", i), 32'(mem_to.data_req_o), 32'd1);
            chk($sformatf("to_gnt%0d/stall_flt", i), {30'd0, t_stall, t_flt}, 32'd2);
            @(negedge clk);
        end
        #1;
        chk("to_gnt/resp_flags", {30'd0, t_mis, t_flt}, 32'd1);
        chk("to_gnt/resp_req", 32'(mem_to.data_req_o), 32'd0);
        chk("to_gnt/resp_stall", 32'(t_stall), 32'd0);
        chk("to_gnt/resp_data", t_ldata, 32'h0);
        @(negedge clk);
        t_req = 1'b0;
        #1;
        chk("to_gnt/after_flt", 32'(t_flt), 32'd0);
        @(negedge clk);

        // Timeout in WAIT_RVAL: granted, response never arrives
        t_req = 1'b1; mem_to.data_gnt_i = 1'b1;
        @(negedge clk);
        mem_to.data_gnt_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("to_rv%0d/stall_flt", i), {30'd0, t_stall, t_flt}, 32'd2);
            @(negedge clk);
        end
        #1;
        chk("to_rv/resp_flags", {30'd0, t_mis, t_flt}, 32'd1);
        chk("to_rv/resp_data", t_ldata, 32'h0);
        @(negedge clk);
        t_req = 1'b0;
        @(negedge clk);

        // Reset while waiting for rvalid; a late rvalid must be ignored
        req = 1'b1; we = 1'b0; size = LDST_W; addr = 32'h0000_0100;
        mem.data_gnt_i = 1'b1;
        @(negedge clk);
        mem.data_gnt_i = 1'b0;
        #1;
        chk("rst_mid/pre_state", 32'(u_dut.state_q), 32'(WAIT_RVAL));
        rst = 1'b1; req = 1'b0;
        #1;
        chk("rst_mid/state", 32'(u_dut.state_q), 32'(IDLE));
        chk("rst_mid/outs", {28'd0, stall, mis, flt, mem.data_req_o}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        mem.data_rvalid_i = 1'b1; mem.data_rdata_i = 32'h1234_5678;
        #1;
        chk("rst_mid/late_rv_outs", {28'd0, stall, mis, flt, mem.data_req_o}, 32'd0);
        @(negedge clk);
        mem.data_rvalid_i = 1'b0; mem.data_rdata_i = 32'h0;
        #1;
        chk("rst_mid/late_state", 32'(u_dut.state_q), 32'(IDLE));
        chk("rst_mid/late_data", ldata, 32'h0);
        chk("rst_mid/late_flags", {30'd0, mis, flt}, 32'd0);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
